pipe_if_id_skid: RTL and testbench
==================================

// Module: pipe_if_id_skid
// PURPOSE
//   Parametrised IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
//   Carries instruction and PC from fetch to decode.
//   Adds decode backpressure, branch flush and bubble insertion to the plain IF/ID register.
//   Sits between the instruction-memory read port and the vector/scalar decoder.
// PARAMETERS
//   N        32   instruction width (bits)
//   PC_W     32   program-counter width (bits)
//   BUBBLE   '0   N-bit encoding driven on instruction_o when no valid entry (NOP)
// PORTS
//   CLK            in   1     clock, all state updates on posedge
//   RST            in   1     synchronous reset, active-high
//   flush_i        in   1     discard all held entries (branch/jump taken)
//   in_valid_i     in   1     fetch presents instruction_i/pc_i
//   in_ready_o     out  1     stage can accept; registered
//   instruction_i  in   N     fetched instruction
//   pc_i           in   PC_W  PC of fetched instruction
//   out_valid_o    out  1     instruction_o/pc_o hold a valid entry
//   out_ready_i    in   1     decode consumes the entry this cycle
//   instruction_o  out  N     head instruction, or BUBBLE when out_valid_o=0
//   pc_o           out  PC_W  head PC, 0 when out_valid_o=0
//   occupancy_o    out  2     entries held: 0, 1 or 2
// BEHAVIOUR
//   Reset (RST=1 at posedge): state=EMPTY, out_valid_o=0, instruction_o=BUBBLE, pc_o=0,
//     in_ready_o=1, occupancy_o=0; RST overrides every other input.
//   in_fire  = in_valid_i & in_ready_o;  out_fire = out_valid_o & out_ready_i.
//   Storage: main slot (drives outputs), skid slot (absorbs one beat under backpressure).
//   States and transitions (no flush):
//     EMPTY: in_fire -> FULL, main<=in; else stay.
//     FULL:  in_fire&out_fire  -> FULL, main<=in.
//            in_fire&!out_fire -> SKID, skid<=in.
//            !in_fire&out_fire -> EMPTY.
//            else hold.
//     SKID:  in_ready_o=0; out_fire -> FULL, main<=skid; else hold both.
//   in_ready_o = (next state != SKID), registered; deasserts the cycle after entering SKID.
//   out_valid_o = (state != EMPTY); occupancy_o = EMPTY:0, FULL:1, SKID:2.
//   Latency: 1 cycle in_fire -> out_valid_o; throughput 1/cycle when out_ready_i held high.
//   Ordering: strict FIFO; no entry dropped or duplicated except by flush.
//   Flush:
//     - flush_i=1 at posedge -> next state EMPTY from any state.
//     - Beat offered same cycle is discarded even if in_fire; out_fire that cycle still counts
//       as consumed.
//     - Next cycle: instruction_o=BUBBLE, pc_o=0, in_ready_o=1.
//   Invalid slots hold no stale data on outputs: instruction_o/pc_o are muxed to BUBBLE/0 when
//     out_valid_o=0.
//   No combinational path in_valid_i->out_valid_o or out_ready_i->in_ready_o.
//   Reset mid-operation: identical to reset from idle; held entries lost.
// STRUCTURE
//   Package pipe_pkg:
//     typedef enum logic[1:0] {EMPTY, FULL, SKID} pipe_state_t;
//     occupancy width constant.
//   Sub-module pipe_slot #(W): load/clear data+valid register with sync clear.
//     Instantiated twice (main, skid) on {instruction, pc}.
//   Top holds FSM, ready register and output bubble mux.
// TESTING
//   1 Reset: RST high 2 cycles -> out_valid_o=0, instruction_o=BUBBLE, in_ready_o=1, occupancy_o=0.
//   2 Stream: 0x11,0x22,0x33 back-to-back, out_ready_i=1 -> each appears 1 cycle later,
//     one per cycle, occupancy_o=1.
//   3 Backpressure: out_ready_i=0, push A=0xA0,B=0xB0 ->
//     occupancy_o=2, in_ready_o=0 next cycle, C=0xC0 held at input;
//     raise out_ready_i -> A,B,C delivered in order.
//   4 Flush in SKID: occupancy_o=2, flush_i=1 with in_valid_i=1 (0xD0) ->
//     next cycle EMPTY, BUBBLE out, 0xD0 never delivered.
//   5 Reset mid-stream: occupancy_o=1, RST=1 -> outputs at reset values;
//     next push 0xE0 -> delivered after 1 cycle.
//   6 Random valid/ready (10k beats) vs scoreboard: order preserved, no loss without flush,
//     in_ready_o=0 only when occupancy_o=2.

Source files
------------

// File: rtl/pipe_if_id_skid_pkg.sv
// Shared types for the IF->ID skid stage: FSM state encoding and occupancy width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_t st);
    logic [OCC_W-1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      FULL:    occ = 2'd1;
      SKID:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_if_id_skid_if.sv
// Fetch-side and decode-side handshake bundle of the IF->ID stage.
interface pipe_if_id_skid_if import pipe_pkg::*; #(
  parameter int N    = 32,
  parameter int PC_W = 32
) ();

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [N-1:0]     instruction_i;
  logic [PC_W-1:0]  pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [N-1:0]     instruction_o;
  logic [PC_W-1:0]  pc_o;
  logic [OCC_W-1:0] occupancy_o;

  modport master (
    output flush_i, in_valid_i, instruction_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, instruction_o, pc_o, occupancy_o
  );

  modport slave (
    input  flush_i, in_valid_i, instruction_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, instruction_o, pc_o, occupancy_o
  );

endinterface

// File: rtl/pipe_if_id_skid_slot.sv
// Data+valid holding register; clear wins over load so a flush always empties the slot.
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Slot storage with clear-before-load priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_if_id_skid.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// branch flush and bubble insertion when no entry is held.
module pipe_if_id_skid import pipe_pkg::*; #(
  parameter int           N      = 32,
  parameter int           PC_W   = 32,
  parameter logic [N-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  pipe_if_id_skid_if.slave bus
);

  localparam int W = N + PC_W;

  pipe_state_t  state_r;
  pipe_state_t  next_state_s;
  logic         in_ready_r;
  logic         in_fire_s;
  logic         out_fire_s;
  logic         out_valid_s;
  logic         main_load_s;
  logic         main_clear_s;
  logic         skid_load_s;
  logic         skid_clear_s;
  logic [W-1:0] in_beat_s;
  logic [W-1:0] main_d_s;
  logic [W-1:0] main_q_s;
  logic [W-1:0] skid_q_s;
  logic         main_valid_s;
  logic         skid_valid_s;

  assign in_beat_s   = {bus.instruction_i, bus.pc_i};
  assign out_valid_s = (state_r != EMPTY);
  assign in_fire_s   = bus.in_valid_i & in_ready_r;
  assign out_fire_s  = out_valid_s & bus.out_ready_i;

  // A held skid beat always has priority as the next head, keeping FIFO order.
  assign main_d_s = skid_valid_s ? skid_q_s : in_beat_s;

  // Next-state and slot control; flush overrides the handshake outcome.
  always_comb begin
    next_state_s = state_r;
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          next_state_s = FULL;
          main_load_s  = 1'b1;
        end else begin
          next_state_s = EMPTY;
        end
      end
      FULL: begin
        if (in_fire_s && out_fire_s) begin
          next_state_s = FULL;
          main_load_s  = 1'b1;
        end else if (in_fire_s) begin
          next_state_s = SKID;
          skid_load_s  = 1'b1;
        end else if (out_fire_s) begin
          next_state_s = EMPTY;
          main_clear_s = 1'b1;
        end else begin
          next_state_s = FULL;
        end
      end
      SKID: begin
        if (out_fire_s) begin
          next_state_s = FULL;
          main_load_s  = 1'b1;
          skid_clear_s = 1'b1;
        end else begin
          next_state_s = SKID;
        end
      end
      default: begin
        next_state_s = EMPTY;
        main_clear_s = 1'b1;
        skid_clear_s = 1'b1;
      end
    endcase
    if (bus.flush_i) begin
      next_state_s = EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State register and registered ready, both derived from the same next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s != SKID);
    end
  end

  pipe_slot #(.W(W)) u_main_slot (
    .clk   (CLK),
    .rst   (RST),
    .load  (main_load_s),
    .clear (main_clear_s),
    .d     (main_d_s),
    .q     (main_q_s),
    .valid (main_valid_s)
  );

  pipe_slot #(.W(W)) u_skid_slot (
    .clk   (CLK),
    .rst   (RST),
    .load  (skid_load_s),
    .clear (skid_clear_s),
    .d     (in_beat_s),
    .q     (skid_q_s),
    .valid (skid_valid_s)
  );

  assign bus.in_ready_o    = in_ready_r;
  assign bus.out_valid_o   = out_valid_s;
  assign bus.instruction_o = main_valid_s ? main_q_s[W-1:PC_W] : BUBBLE;
  assign bus.pc_o          = main_valid_s ? main_q_s[PC_W-1:0] : {PC_W{1'b0}};
  assign bus.occupancy_o   = state_occupancy(state_r);

endmodule

// File: tb/tb_pipe_if_id_skid.sv
// Scoreboard bench for pipe_if_id_skid: directed reset/stream/backpressure/flush
// scenarios followed by a long random valid/ready run.
module tb_pipe_if_id_skid;

  localparam int           N      = 32;
  localparam int           PC_W   = 32;
  localparam logic [N-1:0] BUBBLE = 32'h0000_0013;

  typedef struct packed {
    logic [N-1:0]    instr;
    logic [PC_W-1:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  item_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  int unsigned mon_sz;
  int          beats_in;
  int          cyc;
  bit          accepted;
  bit          dropped;
  logic [31:0] stream_v [3];

  always #5 clk = ~clk;

  pipe_if_id_skid_if #(.N(N), .PC_W(PC_W)) bus ();

  pipe_if_id_skid #(.N(N), .PC_W(PC_W), .BUBBLE(BUBBLE)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] v);
    bus.in_valid_i    = 1'b1;
    bus.instruction_i = v;
    bus.pc_i          = 32'h0000_1000 + v;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
  endtask

  // Scoreboard: compare outputs with the queue model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    mon_sz = sb_q.size();
    if (mon_en) begin
      check_eq("out_valid", 64'(bus.out_valid_o), 64'(mon_sz != 0));
      check_eq("occupancy", 64'(bus.occupancy_o), 64'(mon_sz));
      check_eq("in_ready", 64'(bus.in_ready_o), 64'(mon_sz != 2));
      if (mon_sz != 0) begin
        check_eq("head_instr", 64'(bus.instruction_o), 64'(sb_q[0].instr));
        check_eq("head_pc", 64'(bus.pc_o), 64'(sb_q[0].pc));
      end else begin
        check_eq("bubble_instr", 64'(bus.instruction_o), 64'(BUBBLE));
        check_eq("bubble_pc", 64'(bus.pc_o), 64'd0);
      end
    end
    if (rst) begin
      sb_q.delete();
    end else begin
      if (mon_sz != 0 && bus.out_ready_i) void'(sb_q.pop_front());
      if (bus.flush_i) sb_q.delete();
      else if (bus.in_valid_i && mon_sz != 2)
        sb_q.push_back('{instr: bus.instruction_i, pc: bus.pc_i});
    end
  end

  initial begin
    bus.flush_i       = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.instruction_i = 32'd0;
    bus.pc_i          = 32'd0;
    bus.out_ready_i   = 1'b0;
    rst               = 1'b1;

    // Reset
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check_eq("rst_instr", 64'(bus.instruction_o), 64'(BUBBLE));
    check_eq("rst_pc", 64'(bus.pc_o), 64'd0);
    check_eq("rst_ready", 64'(bus.in_ready_o), 64'd1);
    check_eq("rst_occ", 64'(bus.occupancy_o), 64'd0);

    // Back-to-back stream with decode always ready
    stream_v = '{32'h11, 32'h22, 32'h33};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(stream_v[i]);
      tick();
      check_eq("stream_valid", 64'(bus.out_valid_o), 64'd1);
      check_eq("stream_instr", 64'(bus.instruction_o), 64'(stream_v[i]));
      check_eq("stream_occ", 64'(bus.occupancy_o), 64'd1);
    end
    idle();
    tick();
    check_eq("stream_drain", 64'(bus.occupancy_o), 64'd0);

    // Backpressure into the skid slot
    bus.out_ready_i = 1'b0;
    offer(32'hA0);
    tick();
    check_eq("bp_occ1", 64'(bus.occupancy_o), 64'd1);
    offer(32'hB0);
    tick();
    check_eq("bp_occ2", 64'(bus.occupancy_o), 64'd2);
    check_eq("bp_ready", 64'(bus.in_ready_o), 64'd0);
    check_eq("bp_head", 64'(bus.instruction_o), 64'hA0);
    offer(32'hC0);
    tick();
    check_eq("bp_hold_occ", 64'(bus.occupancy_o), 64'd2);
    check_eq("bp_hold_head", 64'(bus.instruction_o), 64'hA0);
    bus.out_ready_i = 1'b1;
    tick();
    check_eq("bp_b_head", 64'(bus.instruction_o), 64'hB0);
    check_eq("bp_b_ready", 64'(bus.in_ready_o), 64'd1);
    tick();
    check_eq("bp_c_head", 64'(bus.instruction_o), 64'hC0);
    idle();
    tick();
    check_eq("bp_drain", 64'(bus.occupancy_o), 64'd0);

    // Flush while in SKID, with a beat offered
    bus.out_ready_i = 1'b0;
    offer(32'h5A);
    tick();
    offer(32'h5B);
    tick();
    check_eq("fl_skid_occ", 64'(bus.occupancy_o), 64'd2);
    offer(32'hD0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    idle();
    check_eq("fl_occ", 64'(bus.occupancy_o), 64'd0);
    check_eq("fl_valid", 64'(bus.out_valid_o), 64'd0);
    check_eq("fl_instr", 64'(bus.instruction_o), 64'(BUBBLE));
    check_eq("fl_pc", 64'(bus.pc_o), 64'd0);
    check_eq("fl_ready", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    tick();
    check_eq("fl_no_d0", 64'(bus.out_valid_o), 64'd0);

    // Flush in FULL discards an accepted beat
    bus.out_ready_i = 1'b0;
    offer(32'h6A);
    tick();
    check_eq("flf_occ1", 64'(bus.occupancy_o), 64'd1);
    offer(32'hD1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    idle();
    check_eq("flf_occ0", 64'(bus.occupancy_o), 64'd0);
    check_eq("flf_valid", 64'(bus.out_valid_o), 64'd0);

    // Reset mid-stream
    offer(32'h77);
    tick();
    check_eq("mr_occ1", 64'(bus.occupancy_o), 64'd1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mr_valid", 64'(bus.out_valid_o), 64'd0);
    check_eq("mr_instr", 64'(bus.instruction_o), 64'(BUBBLE));
    check_eq("mr_occ0", 64'(bus.occupancy_o), 64'd0);
    check_eq("mr_ready", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    offer(32'hE0);
    tick();
    check_eq("mr_e0_valid", 64'(bus.out_valid_o), 64'd1);
    check_eq("mr_e0_instr", 64'(bus.instruction_o), 64'hE0);
    check_eq("mr_e0_pc", 64'(bus.pc_o), 64'h10E0);
    idle();
    tick();

    // Random valid/ready with rare flushes
    beats_in = 0;
    cyc      = 0;
    while (beats_in < 10000 && cyc < 80000) begin
      if (!bus.in_valid_i && $urandom_range(0, 3) != 0) begin
        bus.in_valid_i    = 1'b1;
        bus.instruction_i = $urandom();
        bus.pc_i          = $urandom();
      end
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      bus.flush_i     = ($urandom_range(0, 399) == 0);
      accepted = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
      dropped  = bus.in_valid_i && bus.flush_i;
      tick();
      cyc++;
      if (accepted) beats_in++;
      if (accepted || dropped) bus.in_valid_i = 1'b0;
    end
    check_eq("rand_budget", 64'(beats_in >= 10000), 64'd1);
    idle();
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) tick();
    check_eq("rand_drain_occ", 64'(bus.occupancy_o), 64'd0);
    check_eq("rand_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
